// File: rtl/fpq_pkg.sv
// fpq_pkg: shared definitions for the flow-priority queue servers.
//   - traffic-class encodings reported on class_tag
//   - server FSM state type (IDLE / READY / GO)
//   - packet-length field width
package fpq_pkg;

  localparam int LEN_W = 8;

  localparam logic [1:0] P_PCF = 2'b00;
  localparam logic [1:0] P_TT  = 2'b01;
  localparam logic [1:0] P_BE  = 2'b10;
  localparam logic [1:0] P_RC  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    GO    = 2'd2
  } srv_state_t;

endpackage

// File: rtl/len_fifo.sv
// len_fifo: synchronous DEPTH x LEN_W descriptor FIFO.
//   clk, rst : clock, synchronous active-high reset (pointers and occupancy only)
//   push     : write din at the tail (caller guarantees !full or a same-edge pop)
//   pop      : drop the head entry (caller guarantees !empty)
//   din      : length to enqueue
//   head     : length at the head of the queue (combinational read)
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module len_fifo
  import fpq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [LEN_W-1:0]           din,
  output logic [LEN_W-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LEN_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; occupancy is
  // tracked separately so full and empty never alias.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/q_fifo_server.sv
// q_fifo_server: requester endpoint of the ready/go/ena_n arbitration
// handshake. Queues packet-length descriptors, requests the arbiter with
// bool_ready while one is pending, and on grant drives bool_go for exactly
// the head packet's length before popping it.
//   clk, rst   : clock, synchronous active-high reset
//   push       : enqueue request; push_len is the packet length (0 illegal)
//   ena_n      : arbiter grant, active low, honoured only in READY
//   bool_ready : descriptor pending and waiting for a grant
//   bool_go    : transmission in progress
//   remain     : go cycles left including the current one, 0 when idle
//   count      : queued descriptors including the one in flight
//   full/empty : occupancy decodes
//   pkt_done   : high during the final go cycle of a packet
//   drop_cnt   : rejected pushes (full or zero length), saturating
//   class_tag  : constant PRIO
module q_fifo_server
  import fpq_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [1:0] PRIO  = P_PCF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [LEN_W-1:0]       push_len,
  input  logic                   ena_n,
  output logic                   bool_ready,
  output logic                   bool_go,
  output logic [LEN_W-1:0]       remain,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   pkt_done,
  output logic [7:0]             drop_cnt,
  output logic [1:0]             class_tag
);

  localparam int CW = $clog2(DEPTH) + 1;

  srv_state_t       state;
  logic             pop;
  logic             push_ok;
  logic             more_after_pop;
  logic [LEN_W-1:0] head;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The head is released on the edge that ends its final go cycle.
  assign pop = (state == GO) && (remain == LEN_W'(1));

  // A full queue can still take a push on the pop edge: the freed slot is
  // the one the write pointer is sitting on.
  assign push_ok = push && (push_len != '0) && (!full || pop);

  // Occupancy left after this edge's pop, counting a same-edge push.
  assign more_after_pop = (count > CW'(1)) || push_ok;

  len_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (push_len),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bool_ready <= 1'b0;
      bool_go    <= 1'b0;
      remain     <= '0;
      pkt_done   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push && !push_ok) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= READY;
            bool_ready <= 1'b1;
          end
        end
        READY: begin
          if (!ena_n) begin
            state      <= GO;
            bool_ready <= 1'b0;
            bool_go    <= 1'b1;
            remain     <= head;
            // pkt_done is registered, so it is raised on the edge that
            // enters the final go cycle (immediately for a 1-cycle packet).
            pkt_done   <= (head == LEN_W'(1));
          end
        end
        GO: begin
          // ena_n is deliberately not examined: transmission is non-preemptive.
          if (remain == LEN_W'(1)) begin
            bool_go <= 1'b0;
            remain  <= '0;
            if (more_after_pop) begin
              state      <= READY;
              bool_ready <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            remain   <= remain - LEN_W'(1);
            pkt_done <= (remain == LEN_W'(2));
          end
        end
        default: begin
          state      <= IDLE;
          bool_ready <= 1'b0;
          bool_go    <= 1'b0;
          remain     <= '0;
        end
      endcase
    end
  end

  assign class_tag = PRIO;

endmodule

// File: tb/tb_q_fifo_server.sv
module tb_q_fifo_server;
  import fpq_pkg::*;

  localparam int         DEPTH = 4;
  localparam logic [1:0] PRIO  = P_BE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_len = 8'd0;
  logic       ena_n = 1'b1;
  logic       bool_ready, bool_go, full, empty, pkt_done;
  logic [7:0] remain, drop_cnt;
  logic [2:0] count;
  logic [1:0] class_tag;

  always #5 clk = ~clk;

  q_fifo_server #(.DEPTH(DEPTH), .PRIO(PRIO)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_len   (push_len),
    .ena_n      (ena_n),
    .bool_ready (bool_ready),
    .bool_go    (bool_go),
    .remain     (remain),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .pkt_done   (pkt_done),
    .drop_cnt   (drop_cnt),
    .class_tag  (class_tag)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of pending lengths; a packet is "waiting" (ready) or "sending"
  // (m_rem cycles left). Outputs after each edge follow directly from these.
  int m_q[$];
  int m_rem   = 0;
  bit m_send  = 1'b0;
  bit m_wait  = 1'b0;
  int m_drops = 0;

  always @(posedge clk) begin : model
    bit finishing, accepted;
    int left;
    if (rst) begin
      m_q.delete();
      m_rem = 0; m_send = 1'b0; m_wait = 1'b0; m_drops = 0;
    end else begin
      finishing = m_send && (m_rem == 1);
      accepted  = push && (push_len != 0) && ((m_q.size() < DEPTH) || finishing);
      if (push && !accepted && m_drops < 255) m_drops++;
      if (m_send) begin
        m_rem--;
        if (m_rem == 0) begin
          m_send = 1'b0;
          left   = m_q.size() - 1 + (accepted ? 1 : 0);
          m_wait = (left > 0);
        end
      end else if (m_wait) begin
        if (!ena_n) begin
          m_wait = 1'b0;
          m_send = 1'b1;
          m_rem  = m_q[0];
        end
      end else begin
        m_wait = (m_q.size() > 0);
      end
      if (finishing) void'(m_q.pop_front());
      if (accepted)  m_q.push_back(int'(push_len));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",        int'(bool_ready), int'(m_wait));
      chk("go",           int'(bool_go),    int'(m_send));
      chk("remain",       int'(remain),     m_rem);
      chk("count",        int'(count),      m_q.size());
      chk("full",         int'(full),       int'(m_q.size() == DEPTH));
      chk("empty",        int'(empty),      int'(m_q.size() == 0));
      chk("pkt_done",     int'(pkt_done),   int'(m_send && m_rem == 1));
      chk("drop_cnt",     int'(drop_cnt),   m_drops);
      chk("class_tag",    int'(class_tag),  2);
      chk("ready_and_go", int'(bool_ready & bool_go), 0);
    end
  end

  task automatic step(input bit p, input int l, input bit e, input bit r);
    push = p; push_len = 8'(l); ena_n = e; rst = r;
    @(posedge clk); #2;
  endtask

  int bursts[$];
  int gaps[$];
  int done_counts[$];
  int exp_b[3] = '{2, 4, 1};
  int exp_c[3] = '{3, 2, 1};

  initial begin
    int run, gap, gocnt;

    // reset
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk_en = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_ready", int'(bool_ready), 0);
    chk("rst_drop",  int'(drop_cnt), 0);

    // single packet, len 3
    step(1, 3, 1, 0);
    chk("t1_count", int'(count), 1);
    chk("t1_ready_early", int'(bool_ready), 0);
    step(0, 0, 1, 0);
    chk("t1_ready", int'(bool_ready), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0);
      chk("t1_ready_hold", int'(bool_ready), 1);
      chk("t1_no_go", int'(bool_go), 0);
    end
    step(0, 0, 0, 0);
    chk("t1_go1", int'(bool_go), 1);
    chk("t1_rem3", int'(remain), 3);
    chk("t1_done1", int'(pkt_done), 0);
    step(0, 0, 1, 0);
    chk("t1_rem2", int'(remain), 2);
    step(0, 0, 1, 0);
    chk("t1_rem1", int'(remain), 1);
    chk("t1_done3", int'(pkt_done), 1);
    step(0, 0, 1, 0);
    chk("t1_go_off", int'(bool_go), 0);
    chk("t1_empty", int'(empty), 1);
    chk("t1_done_off", int'(pkt_done), 0);

    // back-to-back 2,4,1 with permanent grant
    step(0, 0, 1, 1);
    step(1, 2, 0, 0);
    step(1, 4, 0, 0);
    step(1, 1, 0, 0);
    run = 0; gap = 0;
    for (int i = 0; i < 25; i++) begin
      if (pkt_done) done_counts.push_back(int'(count));
      if (bool_go) begin
        if (run == 0 && bursts.size() > 0) gaps.push_back(gap);
        run++;
      end else begin
        if (run > 0) begin bursts.push_back(run); run = 0; gap = 0; end
        if (bool_ready) gap++;
      end
      step(0, 0, 0, 0);
    end
    chk("b2b_nbursts", bursts.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_burst", (i < bursts.size()) ? bursts[i] : -1, exp_b[i]);
      chk("b2b_count", (i < done_counts.size()) ? done_counts[i] : -1, exp_c[i]);
    end
    chk("b2b_ngaps", gaps.size(), 2);
    for (int i = 0; i < 2; i++)
      chk("b2b_gap", (i < gaps.size()) ? gaps[i] : -1, 1);
    chk("b2b_final_count", int'(count), 0);
    chk("b2b_idle_grant_go", int'(bool_go), 0);

    // full and drops
    step(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 2, 1, 0);
      if (i == 3) begin
        chk("full_after4", int'(full), 1);
        chk("full_count4", int'(count), 4);
      end
    end
    chk("full_drops", int'(drop_cnt), 2);
    step(0, 0, 0, 0);
    chk("full_go", int'(bool_go), 1);
    step(0, 0, 1, 0);
    chk("full_last_cycle", int'(remain), 1);
    step(1, 5, 1, 0);
    chk("full_pushpop_count", int'(count), 4);
    chk("full_pushpop_drops", int'(drop_cnt), 2);
    chk("full_pushpop_ready", int'(bool_ready), 1);

    // illegal length and ignored grant
    step(0, 0, 1, 1);
    step(1, 0, 1, 0);
    chk("len0_drop", int'(drop_cnt), 1);
    chk("len0_count", int'(count), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("empty_grant_go", int'(bool_go), 0);
    end

    // non-preemption, len 8
    step(0, 0, 1, 1);
    step(1, 8, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    gocnt = int'(bool_go);
    step(0, 0, 0, 0);
    gocnt += int'(bool_go);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 0);
      gocnt += int'(bool_go);
    end
    chk("nonpreempt_len", gocnt, 8);

    // reset mid-transmission, len 6
    step(0, 0, 1, 1);
    step(1, 0, 1, 0);
    step(1, 6, 1, 0);
    step(1, 3, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("midrst_rem_before", int'(remain), 4);
    chk("midrst_drop_before", int'(drop_cnt), 1);
    step(0, 0, 1, 1);
    chk("midrst_go", int'(bool_go), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_remain", int'(remain), 0);
    chk("midrst_drop", int'(drop_cnt), 0);
    chk("midrst_done", int'(pkt_done), 0);

    // drop counter saturation
    for (int i = 0; i < 260; i++) step(1, 0, 1, 0);
    chk("drop_saturate", int'(drop_cnt), 255);

    // randomized traffic
    step(0, 0, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 45,
           $urandom_range(0, 9),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 299) == 0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
